// File: rtl/ai_core_pkg.sv
// Shared types and helpers for the AI datapath: multiplier product and
// accumulator widths, saturation limits and a saturating accumulate.
package ai_core_pkg;

  localparam int PROD_W_DEF = 12;
  localparam int ACC_W_DEF  = 20;

  typedef logic signed [PROD_W_DEF-1:0] prod_t;
  typedef logic signed [ACC_W_DEF-1:0]  acc_t;

  localparam acc_t ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  // One guard bit is enough: the sum of an ACC_W and a narrower value
  // cannot wrap past ACC_W+1 bits.
  function automatic acc_t sat_add(input acc_t a, input prod_t p, output logic ovf);
    logic [ACC_W_DEF:0] s;
    s   = {a[ACC_W_DEF-1], a} + {{(ACC_W_DEF+1-PROD_W_DEF){p[PROD_W_DEF-1]}}, p};
    ovf = s[ACC_W_DEF] ^ s[ACC_W_DEF-1];
    if (ovf)
      return s[ACC_W_DEF] ? ACC_MIN : ACC_MAX;
    return acc_t'(s[ACC_W_DEF-1:0]);
  endfunction

endpackage

// File: rtl/dot_accumulator_if.sv
// Handshake bundle between the multiplier, the dot-product accumulator and
// the result consumer.
interface dot_accumulator_if
  import ai_core_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
);
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic signed [PROD_W-1:0] in_prod_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic signed [ACC_W-1:0]  out_sum_o;
  logic                     out_ovf_o;
  logic                     busy_o;

  modport master (
    output in_valid_i, in_prod_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_sum_o, out_ovf_o, busy_o
  );

  modport slave (
    input  in_valid_i, in_prod_i, out_ready_i,
    output in_ready_o, out_valid_o, out_sum_o, out_ovf_o, busy_o
  );
endinterface

// File: rtl/dot_accumulator_sat_adder.sv
// Combinational saturating add of a signed product into a signed accumulator,
// with a flag raised whenever the result had to be clamped.
module sat_adder
  import ai_core_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0]  a,
  input  logic signed [PROD_W-1:0] b,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);

  generate
    if (ACC_W == ACC_W_DEF && PROD_W == PROD_W_DEF) begin : g_pkg
      acc_t sum_next;
      logic ovf_next;
      always_comb begin
        ovf_next = 1'b0;
        sum_next = sat_add(acc_t'(a), prod_t'(b), ovf_next);
      end
      assign sum = sum_next;
      assign ovf = ovf_next;
    end else begin : g_generic
      logic [ACC_W:0] raw;
      assign raw = {a[ACC_W-1], a} + {{(ACC_W+1-PROD_W){b[PROD_W-1]}}, b};
      assign ovf = raw[ACC_W] ^ raw[ACC_W-1];
      assign sum = !ovf       ? raw[ACC_W-1:0] :
                   raw[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                {1'b0, {(ACC_W-1){1'b1}}};
    end
  endgenerate

endmodule

// File: rtl/dot_accumulator.sv
// Accumulates VEC_LEN signed products into a saturating dot-product and
// hands the result out through a single-entry valid/ready register.
module dot_accumulator
  import ai_core_pkg::*;
#(
  parameter int PROD_W  = PROD_W_DEF,
  parameter int VEC_LEN = 16,
  parameter int ACC_W   = ACC_W_DEF
) (
  input logic             clk_i,
  input logic             rst_i,
  dot_accumulator_if.slave bus
);

  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

  logic signed [ACC_W-1:0] acc_reg;
  logic                    ovf_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    out_valid_reg;
  logic signed [ACC_W-1:0] out_sum_reg;
  logic                    out_ovf_reg;

  logic signed [ACC_W-1:0] sum_next;
  logic                    clamp_next;
  logic                    is_last;
  logic                    in_ready;
  logic                    accept;
  logic                    drain;

  sat_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_sat_adder (
    .a   (acc_reg),
    .b   (bus.in_prod_i),
    .sum (sum_next),
    .ovf (clamp_next)
  );

  assign is_last  = (cnt_reg == LAST);
  // Only the closing product of a vector needs the output register free.
  assign in_ready = !(out_valid_reg && !bus.out_ready_i && is_last);
  assign accept   = bus.in_valid_i && in_ready;
  assign drain    = out_valid_reg && bus.out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_sum_reg   <= '0;
      out_ovf_reg   <= 1'b0;
    end else begin
      if (drain)
        out_valid_reg <= 1'b0;
      if (accept) begin
        if (is_last) begin
          out_sum_reg   <= sum_next;
          out_ovf_reg   <= ovf_reg | clamp_next;
          out_valid_reg <= 1'b1;
          acc_reg       <= '0;
          ovf_reg       <= 1'b0;
          cnt_reg       <= '0;
        end else begin
          acc_reg <= sum_next;
          ovf_reg <= ovf_reg | clamp_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_reg;
  assign bus.out_sum_o   = out_sum_reg;
  assign bus.out_ovf_o   = out_ovf_reg;
  assign bus.busy_o      = (cnt_reg != '0);

endmodule

// File: tb/tb_dot_accumulator.sv
// Scoreboard bench for dot_accumulator (PROD_W=12, ACC_W=12, VEC_LEN=4):
// the driver queues expected results, a monitor pops them on each output handshake.
module tb_dot_accumulator;

  localparam int PW = 12;
  localparam int AW = 12;
  localparam int VL = 4;
  localparam int AMAX = 2047;
  localparam int AMIN = -2048;

  typedef struct {
    int sum;
    bit ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dot_accumulator_if #(.PROD_W(PW), .ACC_W(AW)) bus ();

  dot_accumulator #(.PROD_W(PW), .VEC_LEN(VL), .ACC_W(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   rdy_mode = 1;   // 0: hold low, 1: high, 2: random
  int   stalls   = 0;
  bit   was_last = 0;
  longint acc_m  = 0;
  bit   ovf_m    = 0;
  int   cnt_m    = 0;

  initial begin
    bus.out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready_i = 1'b0;
        1:       bus.out_ready_i = 1'b1;
        default: bus.out_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: result check on every output handshake, plus hold-stability check.
  bit   hold_prev = 0;
  int   prev_sum;
  bit   prev_ovf;
  int   got;
  exp_t e;
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 0;
    end else begin
      got = int'(bus.out_sum_o);
      if (hold_prev) begin
        checks++;
        if (!(bus.out_valid_o && got == prev_sum && bus.out_ovf_o == prev_ovf)) begin
          failures++;
          $display("FAIL hold: valid=%0b sum=%0d ovf=%0b required valid=1 sum=%0d ovf=%0b",
                   bus.out_valid_o, got, bus.out_ovf_o, prev_sum, prev_ovf);
        end
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL result: unexpected output sum=%0d ovf=%0b", got, bus.out_ovf_o);
        end else begin
          e = q.pop_front();
          if (got != e.sum || bus.out_ovf_o != e.ovf) begin
            failures++;
            $display("FAIL result: sum=%0d ovf=%0b required sum=%0d ovf=%0b",
                     got, bus.out_ovf_o, e.sum, e.ovf);
          end else begin
            $display("result sum=%0d ovf=%0b ok", got, bus.out_ovf_o);
          end
        end
      end
      hold_prev = bus.out_valid_o && !bus.out_ready_i;
      prev_sum  = got;
      prev_ovf  = bus.out_ovf_o;
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Stand-in for the upstream 4b x 8b signed multiplier.
  function automatic int mul(input logic signed [3:0] a, input logic signed [7:0] b);
    return int'(a) * int'(b);
  endfunction

  task automatic model_accept(input int p, input bit hand, input int hs, input bit ho);
    exp_t x;
    acc_m = acc_m + longint'(p);
    if (acc_m > AMAX) begin acc_m = AMAX; ovf_m = 1; end
    if (acc_m < AMIN) begin acc_m = AMIN; ovf_m = 1; end
    cnt_m++;
    was_last = (cnt_m == VL);
    if (was_last) begin
      x.sum = hand ? hs : int'(acc_m);
      x.ovf = hand ? ho : ovf_m;
      q.push_back(x);
      acc_m = 0; ovf_m = 0; cnt_m = 0;
    end
  endtask

  task automatic send(input int p, input bit hand = 0, input int hs = 0, input bit ho = 0);
    bit accepted = 0;
    int waited   = 0;
    bus.in_valid_i = 1'b1;
    bus.in_prod_i  = PW'(p);
    while (!accepted) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        model_accept(p, hand, hs, ho);
        accepted = 1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
      if (!accepted && ++waited > 200) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    if (accepted && was_last)
      check("latency_valid", int'(bus.out_valid_o), 1);
  endtask

  task automatic idle(input int n);
    bus.in_valid_i = 1'b0;
    repeat (n) begin
      bus.in_prod_i = PW'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic vec(input int p0, input int p1, input int p2, input int p3,
                     input int hs, input bit ho);
    send(p0); send(p1); send(p2); send(p3, 1, hs, ho);
  endtask

  initial begin
    #900_000;
    failures++;
    $display("FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bit ok;
    bus.in_valid_i = 1'b0;
    bus.in_prod_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(bus.out_valid_o), 0);
    check("rst_out_sum", int'(bus.out_sum_o), 0);
    check("rst_out_ovf", int'(bus.out_ovf_o), 0);
    check("rst_busy", int'(bus.busy_o), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", int'(bus.in_ready_o), 1);

    // Basic vector
    send(3); send(-5);
    check("busy_mid", int'(bus.busy_o), 1);
    send(7); send(100, 1, 105, 0);
    idle(2);

    // Negative saturation, then a clean vector
    vec(-2048, -2048, -2048, -2048, -2048, 1);
    vec(1, 1, 1, 1, 4, 0);
    idle(2);

    // Consumer stall: earlier elements keep flowing, the last one waits
    rdy_mode = 0;
    idle(1);
    vec(10, 20, 30, 40, 100, 0);
    stalls = 0;
    send(1); send(2); send(3);
    check("stall_early_accepts", stalls, 0);
    bus.in_valid_i = 1'b1;
    bus.in_prod_i  = PW'(4);
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", int'(bus.in_ready_o), 0);
      @(posedge clk);
      #1;
    end
    rdy_mode = 1;
    ok = 0;
    for (int i = 0; i < 5 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        model_accept(4, 1, 10, 0);
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    check("stall_release", int'(ok), 1);
    check("stall_new_valid", int'(bus.out_valid_o), 1);
    idle(2);

    // Back-to-back vectors at full rate
    stalls = 0;
    vec(1, 2, 3, 4, 10, 0);
    vec(-1, -2, -3, -4, -10, 0);
    vec(500, 500, 500, 500, 2000, 0);
    check("b2b_no_stall", stalls, 0);
    idle(1);

    // Extreme multiplier products
    vec(mul(-8, -128), mul(-8, -128), mul(-8, 127), mul(-8, 127), 15, 1);
    vec(mul(-8, 127), mul(-8, 127), mul(-8, 127), mul(-8, 127), -2048, 1);
    idle(2);

    // Async reset with a pending result and a partial vector
    rdy_mode = 0;
    idle(1);
    vec(5, 5, 5, 5, 20, 0);
    send(7); send(8);
    bus.in_valid_i = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", int'(bus.out_valid_o), 0);
    check("arst_out_sum", int'(bus.out_sum_o), 0);
    check("arst_busy", int'(bus.busy_o), 0);
    q.delete();
    acc_m = 0; ovf_m = 0; cnt_m = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 1;
    @(posedge clk);
    #1;
    vec(1, 2, 3, 4, 10, 0);
    idle(2);

    // Random multiplier operands, random gaps and consumer backpressure
    rdy_mode = 2;
    for (int v = 0; v < 1000; v++) begin
      for (int k = 0; k < VL; k++) begin
        send(mul(4'($urandom), 8'($urandom)));
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    idle(1);
    rdy_mode = 1;
    for (int i = 0; i < 50 && (q.size() != 0 || bus.out_valid_o); i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_queue_empty", q.size(), 0);
    check("drain_out_valid", int'(bus.out_valid_o), 0);
    check("final_busy", int'(bus.busy_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
